// File: rtl/channel_merge_accum.sv
// Merges CH skewed channel streams: per-channel skew FIFOs, a registered adder tree,
// then a saturating output register with frame tracking. Optional macro MERGE_RELU_EN clamps negatives to 0.
module channel_merge_accum #(
   parameter int CH         = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int D          = 147
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [CH-1:0]                valid_in,
   input  logic [CH*DATA_WIDTH-1:0]     pxl_in,
   output logic [DATA_WIDTH-1:0]        pxl_out,
   output logic                         valid_out,
   output logic                         frame_last,
   output logic                         overflow_err
);

   localparam int LVL   = $clog2(CH);
   localparam int NP    = 1 << LVL;
   localparam int ACC_W = DATA_WIDTH + LVL;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = (D > 1) ? $clog2(D) : 1;
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
   localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

   logic [DATA_WIDTH-1:0]     mem_q  [CH][FIFO_DEPTH];
   logic [AW:0]               wptr_q [CH];
   logic [AW:0]               rptr_q [CH];
   logic [CH-1:0]             empty, full, push;
   logic                      pop;
   logic                      ovf_q;

   logic signed [ACC_W-1:0]   lane   [NP];
   logic signed [ACC_W-1:0]   tree_q [LVL+1][NP];
   logic [LVL:0]              vld_q;

   logic signed [ACC_W-1:0]   sum;
   logic [DATA_WIDTH-1:0]     sat;
   logic [DATA_WIDTH-1:0]     pxl_out_q;
   logic                      valid_out_q, frame_last_q;
   logic [CW-1:0]             col_q, row_q;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_comb begin
      empty = '0;
      full  = '0;
      for (int i = 0; i < CH; i++) begin
         empty[i] = (wptr_q[i] == rptr_q[i]);
         full[i]  = (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]) && (wptr_q[i][AW] != rptr_q[i][AW]);
      end
      pop  = &(~empty);
      push = '0;
      for (int i = 0; i < CH; i++) begin
         push[i] = valid_in[i] && (!full[i] || pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < CH; i++) begin
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
         end
         ovf_q <= 1'b0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
            if (pop)     rptr_q[i] <= rptr_q[i] + 1'b1;
         end
         if (|(valid_in & ~push)) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < CH; i++) begin
         if (push[i]) mem_q[i][wptr_q[i][AW-1:0]] <= pxl_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Lanes beyond CH are zero so the power-of-two tree behaves as odd pass-through.
   always_comb begin
      for (int j = 0; j < NP; j++) lane[j] = '0;
      for (int j = 0; j < CH; j++) lane[j] = ACC_W'($signed(mem_q[j][rptr_q[j][AW-1:0]]));
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < NP; j++) tree_q[0][j] <= lane[j];
      for (int l = 1; l <= LVL; l++) begin
         for (int j = 0; j < (NP >> l); j++) begin
            tree_q[l][j] <= tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= pop;
         for (int l = 1; l <= LVL; l++) vld_q[l] <= vld_q[l-1];
      end
   end

   always_comb begin
      sum = tree_q[LVL][0];
      if (sum > MAXV)      sat = MAXV[DATA_WIDTH-1:0];
      else if (sum < MINV) sat = MINV[DATA_WIDTH-1:0];
      else                 sat = sum[DATA_WIDTH-1:0];
`ifdef MERGE_RELU_EN
      if (sat[DATA_WIDTH-1]) sat = '0;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pxl_out_q    <= '0;
         valid_out_q  <= 1'b0;
         frame_last_q <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
      end else begin
         valid_out_q  <= vld_q[LVL];
         frame_last_q <= vld_q[LVL] && (col_q == CW'(D-1)) && (row_q == CW'(D-1));
         if (vld_q[LVL]) begin
            pxl_out_q <= sat;
            if (col_q == CW'(D-1)) begin
               col_q <= '0;
               row_q <= (row_q == CW'(D-1)) ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
      end
   end

   assign pxl_out      = pxl_out_q;
   assign valid_out    = valid_out_q;
   assign frame_last   = frame_last_q;
   assign overflow_err = ovf_q;

endmodule
